stopwatch_display: RTL and testbench

- Consumer of the clock-divider outputs (1 MHz `clk_in`, 1 kHz and 10 Hz square waves).
- Runs entirely on `clk_in` and converts the divider outputs into single-cycle ticks.
- Keeps a BCD stopwatch (M:SS.t, 0:00.0 to 9:59.9) that advances on 10 Hz ticks.
- Debounces two push-buttons and scans a 4-digit multiplexed 7-segment display on 1 kHz ticks.

---
 rtl/stopwatch_display.sv | 114 +++++++++++
 tb/tb_stopwatch_display.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_display.sv
// stopwatch_display: BCD stopwatch M:SS.t with debounced run/clear buttons and a 4-digit multiplexed 7-segment scan.
module stopwatch_display #(
  parameter int DEB_COUNT = 20
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        clk_1kHz,
  input  logic        clk_10Hz,
  input  logic        btn_run,
  input  logic        btn_clr,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        running,
  output logic [15:0] bcd
);
  logic [1:0] s1k, s10, btn, press, idx;
  logic       d1k, d10, tick_1k, tick_10;
  logic [3:0] tn, su, st, mn, dig;
  logic [6:0] code;
  assign btn = {btn_clr, btn_run};
  assign bcd = {mn, st, su, tn};
  // registered edge detect so every tick lands one full cycle after the synchronizer
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      s1k <= '0;
      s10 <= '0;
      d1k <= 1'b0;
      d10 <= 1'b0;
      tick_1k <= 1'b0;
      tick_10 <= 1'b0;
    end else begin
      s1k <= {s1k[0], clk_1kHz};
      s10 <= {s10[0], clk_10Hz};
      d1k <= s1k[1];
      d10 <= s10[1];
      tick_1k <= s1k[1] & ~d1k;
      tick_10 <= s10[1] & ~d10;
    end
  for (genvar b = 0; b < 2; b++) begin : g_deb
    logic [1:0] s;
    logic       stable, p;
    logic [7:0] cnt;
    assign press[b] = p;
    always_ff @(posedge clk_in or posedge rst)
      if (rst) begin
        s <= '0;
        stable <= 1'b0;
        cnt <= '0;
        p <= 1'b0;
      end else begin
        s <= {s[0], btn[b]};
        p <= 1'b0;
        if (tick_1k) begin
          if (s[1] == stable) cnt <= '0;
          else if (cnt == 8'(DEB_COUNT - 1)) begin
            stable <= s[1];
            cnt <= '0;
            p <= s[1];
          end else cnt <= cnt + 8'd1;
        end
      end
  end
  // clear outranks both the run toggle and a same-cycle increment
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      {mn, st, su, tn} <= '0;
      running <= 1'b0;
    end else if (press[1]) begin
      {mn, st, su, tn} <= '0;
      running <= 1'b0;
    end else begin
      if (press[0]) running <= ~running;
      if (tick_10 && running) begin
        tn <= tn == 4'd9 ? 4'd0 : tn + 4'd1;
        if (tn == 4'd9) begin
          su <= su == 4'd9 ? 4'd0 : su + 4'd1;
          if (su == 4'd9) begin
            st <= st == 4'd5 ? 4'd0 : st + 4'd1;
            if (st == 4'd5) mn <= mn == 4'd9 ? 4'd0 : mn + 4'd1;
          end
        end
      end
    end
  assign dig = bcd[{idx, 2'b00} +: 4];
  always_comb begin
    code = 7'b1111111;
    case (dig)
      4'd0: code = 7'b1000000;
      4'd1: code = 7'b1111001;
      4'd2: code = 7'b0100100;
      4'd3: code = 7'b0110000;
      4'd4: code = 7'b0011001;
      4'd5: code = 7'b0010010;
      4'd6: code = 7'b0000010;
      4'd7: code = 7'b1111000;
      4'd8: code = 7'b0000000;
      4'd9: code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      idx <= '0;
      an <= 4'b1110;
      seg <= 7'b1000000;
      dp <= 1'b1;
    end else begin
      idx <= idx + 2'(tick_1k);
      an <= ~(4'b0001 << idx);
      seg <= code;
      dp <= ~idx[0];
    end
endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: directed checks of reset, tick latency, debounce, counting/wrap, priority and scan decode.
`timescale 1ns/1ps
module tb_stopwatch_display;
  logic clk_in = 0, rst = 1, clk_1kHz = 0, clk_10Hz = 0, btn_run = 0, btn_clr = 0;
  logic [6:0]  seg;
  logic        dp, running;
  logic [3:0]  an;
  logic [15:0] bcd;
  int tests = 0, fails = 0, n1k = 0, scan = 0;
  bit coin = 0;
  stopwatch_display #(.DEB_COUNT(4)) dut (
    .clk_in(clk_in), .rst(rst), .clk_1kHz(clk_1kHz), .clk_10Hz(clk_10Hz),
    .btn_run(btn_run), .btn_clr(btn_clr), .seg(seg), .dp(dp), .an(an),
    .running(running), .bcd(bcd)
  );
  always #500 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    if (dut.tick_1k) n1k <= n1k + 1;
    if (dut.tick_10 && dut.press == 2'b11) coin <= 1'b1;
  end
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic t1k;
    @(negedge clk_in) clk_1kHz = 1;
    repeat (3) @(negedge clk_in);
    clk_1kHz = 0;
    repeat (3) @(negedge clk_in);
    scan++;
  endtask
  task automatic t10;
    @(negedge clk_in) clk_10Hz = 1;
    repeat (2) @(negedge clk_in);
    clk_10Hz = 0;
    repeat (2) @(negedge clk_in);
  endtask
  task automatic press_run;
    btn_run = 1;
    repeat (4) t1k();
    btn_run = 0;
    repeat (4) t1k();
  endtask
  initial begin
    logic [3:0] ea [4];
    logic [6:0] es [4];
    logic       ed [4];
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    es = '{7'b1111000, 7'b1000000, 7'b0010010, 7'b0110000};
    ed = '{1'b1, 1'b0, 1'b1, 1'b0};
    repeat (3) @(negedge clk_in);
    rst = 0;
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_run", 16'(running), 16'h0);
    chk("rst_an", 16'(an), 16'h000e);
    chk("rst_seg", 16'(seg), 16'h0040);
    chk("rst_dp", 16'(dp), 16'h1);
    // tick latency: rise before edge k, tick during cycle after k+2
    n1k = 0;
    @(negedge clk_in) clk_1kHz = 1;
    @(negedge clk_in) chk("tick_k", 16'(dut.tick_1k), 16'h0);
    @(negedge clk_in) chk("tick_k1", 16'(dut.tick_1k), 16'h0);
    @(negedge clk_in) chk("tick_k2", 16'(dut.tick_1k), 16'h1);
    @(negedge clk_in) chk("tick_k3", 16'(dut.tick_1k), 16'h0);
    chk("an_hold", 16'(an), 16'h000e);
    @(negedge clk_in) chk("an_step", 16'(an), 16'h000d);
    clk_1kHz = 0;
    repeat (6) @(negedge clk_in);
    scan++;
    chk("an_fall", 16'(an), 16'h000d);
    chk("tick_cnt", 16'(n1k), 16'd1);
    // debounce with bounce then a 4-tick hold
    btn_run = 1; t1k();
    btn_run = 1; t1k();
    btn_run = 0; t1k();
    btn_run = 1;
    repeat (3) t1k();
    chk("deb_early", 16'(running), 16'h0);
    t1k();
    chk("deb_on", 16'(running), 16'h1);
    btn_run = 0;
    repeat (4) t1k();
    chk("deb_rel", 16'(running), 16'h1);
    btn_run = 1;
    repeat (4) t1k();
    chk("deb_off", 16'(running), 16'h0);
    btn_run = 0;
    repeat (4) t1k();
    // counting with carries up to 1:23.4
    press_run();
    chk("run_on", 16'(running), 16'h1);
    t10();
    chk("cnt_1", bcd, 16'h0001);
    repeat (9) t10();
    chk("cnt_10", bcd, 16'h0010);
    repeat (590) t10();
    chk("cnt_600", bcd, 16'h1000);
    repeat (234) t10();
    chk("cnt_834", bcd, 16'h1234);
    // asynchronous reset mid-operation
    @(negedge clk_in) rst = 1;
    #1;
    chk("arst_bcd", bcd, 16'h0000);
    chk("arst_run", 16'(running), 16'h0);
    chk("arst_an", 16'(an), 16'h000e);
    chk("arst_seg", 16'(seg), 16'h0040);
    chk("arst_dp", 16'(dp), 16'h1);
    @(negedge clk_in) rst = 0;
    scan = 0;
    // wrap from 9:59.8
    press_run();
    repeat (5998) t10();
    chk("wrap_pre", bcd, 16'h9598);
    t10();
    chk("wrap_9599", bcd, 16'h9599);
    t10();
    chk("wrap_0", bcd, 16'h0000);
    chk("wrap_run", 16'(running), 16'h1);
    // clr, run and tick_10 coincide
    t10();
    chk("pri_pre", bcd, 16'h0001);
    btn_run = 1;
    btn_clr = 1;
    repeat (3) t1k();
    @(negedge clk_in) clk_1kHz = 1;
    @(negedge clk_in) clk_10Hz = 1;
    repeat (3) @(negedge clk_in);
    clk_1kHz = 0;
    clk_10Hz = 0;
    repeat (3) @(negedge clk_in);
    scan++;
    chk("pri_coin", 16'(coin), 16'h1);
    chk("pri_bcd", bcd, 16'h0000);
    chk("pri_run", 16'(running), 16'h0);
    btn_run = 0;
    btn_clr = 0;
    repeat (4) t1k();
    // scan decode of 3:50.7
    press_run();
    repeat (2307) t10();
    press_run();
    chk("scan_run", 16'(running), 16'h0);
    chk("scan_bcd", bcd, 16'h3507);
    while (scan % 4 != 3) t1k();
    for (int i = 0; i < 4; i++) begin
      t1k();
      chk($sformatf("scan_an%0d", i), 16'(an), 16'(ea[i]));
      chk($sformatf("scan_seg%0d", i), 16'(seg), 16'(es[i]));
      chk($sformatf("scan_dp%0d", i), 16'(dp), 16'(ed[i]));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
